uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: transmit half of a UART with a one-entry holding buffer.
//
// A producer hands over one data word per valid/ready handshake at the full
// clk rate. The word waits in a holding buffer until the serialiser is free.
// It is then framed as: start (0), DATA_BITS data bits LSB first, an
// optional odd-parity bit, and STOP_BITS stop bits (1). Every bit lasts
// OVS_FACTOR pulses of tick_16x. A word already buffered when a frame ends
// launches straight away, with no idle gap on the line.
//
// Parameters
//   DATA_BITS     data bits per frame (5..15)
//   OVS_FACTOR    tick_16x pulses per bit period (4..31)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clk           single clock; all state updates on its rising edge
//   reset         asynchronous, active-low
//   tick_16x      oversample enable, high for one clk per oversample period
//   tx_data       word to send, captured on handshake
//   tx_valid      producer request
//   tx_ready      holding buffer empty; a handshake completes on valid & ready
//   parity_enable odd-parity select, sampled when a frame launches
//   tx_pin        registered serial line, idle high
//   tx_busy       serialiser not idle
//   tx_done       one-clk pulse on the tick that ends a frame's stop period
module uart_tx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVS_FACTOR = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_enable,
  output logic                 tx_pin,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned OsW   = $clog2(OVS_FACTOR);
  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam int unsigned StopW = $clog2(STOP_BITS + 1);

  localparam logic [OsW-1:0]   OsLast   = OsW'(OVS_FACTOR - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);
  localparam logic [StopW-1:0] StopLast = StopW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   buf_q, buf_d;
  logic                   buf_full_q, buf_full_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_en_q, par_en_d;
  logic [OsW-1:0]         os_q, os_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [StopW-1:0]       stop_q, stop_d;
  logic                   pin_q, pin_d;
  logic                   done_q, done_d;

  // launch: the buffered word moves into the serialiser on this tick.
  // frame_end: this tick is the last one of the stop period.
  logic                   launch;
  logic                   frame_end;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      os_q       <= '0;
      bit_q      <= '0;
      stop_q     <= '0;
      pin_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      os_q       <= os_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      pin_q      <= pin_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    os_d       = os_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    launch     = 1'b0;
    frame_end  = 1'b0;

    // Accept needs an empty buffer and launch needs a full one, so the two
    // never touch buf_full_d in the same cycle.
    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    if (tick_16x) begin
      if (state_q == StIdle) begin
        launch = buf_full_q;
      end else if (os_q != OsLast) begin
        os_d = os_q + OsW'(1);
      end else begin
        os_d = '0;
        unique case (state_q)
          StStart: begin
            state_d = StData;
          end
          StData: begin
            if (bit_q == BitLast) begin
              bit_d   = '0;
              state_d = par_en_q ? StParity : StStop;
            end else begin
              bit_d = bit_q + BitW'(1);
            end
          end
          StParity: begin
            state_d = StStop;
          end
          StStop: begin
            if (stop_q == StopLast) begin
              stop_d    = '0;
              frame_end = 1'b1;
              if (buf_full_q) begin
                launch = 1'b1;
              end else begin
                state_d = StIdle;
              end
            end else begin
              stop_d = stop_q + StopW'(1);
            end
          end
          default: begin
            state_d = StIdle;
          end
        endcase
      end
    end

    if (launch) begin
      shift_d    = buf_q;
      buf_full_d = 1'b0;
      par_en_d   = parity_enable;
      os_d       = '0;
      bit_d      = '0;
      stop_d     = '0;
      state_d    = StStart;
    end
  end

  // Outputs. The line level is computed from the next state so that tx_pin
  // changes on the same edge as the state register.
  always_comb begin
    tx_ready = ~buf_full_q;
    tx_busy  = (state_q != StIdle);
    done_d   = frame_end;
    pin_d    = 1'b1;
    unique case (state_d)
      StStart:  pin_d = 1'b0;
      StData:   pin_d = shift_d[bit_d];
      // Odd parity: the ones in data plus parity total an odd number.
      StParity: pin_d = ~^shift_d;
      default:  pin_d = 1'b1;
    endcase
  end

  assign tx_pin  = pin_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } frame_t;

  logic       clk;
  logic       reset;
  logic       tick_16x;
  logic       tick_en;
  int         tick_div;

  logic [7:0] tx_data0, tx_data1;
  logic       tx_valid0, tx_valid1;
  logic       tx_ready0, tx_ready1;
  logic       par_en0, par_en1;
  logic       tx_pin0, tx_pin1;
  logic       tx_busy0, tx_busy1;
  logic       tx_done0, tx_done1;

  int checks = 0;
  int errors = 0;
  int done0 = 0, done1 = 0;
  int frames0 = 0, frames1 = 0;
  int b2b0 = 0, b2b1 = 0;

  frame_t sb0[$];
  frame_t sb1[$];

  uart_tx u_dut0 (
    .clk          (clk),
    .reset        (reset),
    .tick_16x     (tick_16x),
    .tx_data      (tx_data0),
    .tx_valid     (tx_valid0),
    .tx_ready     (tx_ready0),
    .parity_enable(par_en0),
    .tx_pin       (tx_pin0),
    .tx_busy      (tx_busy0),
    .tx_done      (tx_done0)
  );

  uart_tx #(
    .DATA_BITS (8),
    .OVS_FACTOR(8),
    .STOP_BITS (2)
  ) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .tick_16x     (tick_16x),
    .tx_data      (tx_data1),
    .tx_valid     (tx_valid1),
    .tx_ready     (tx_ready1),
    .parity_enable(par_en1),
    .tx_pin       (tx_pin1),
    .tx_busy      (tx_busy1),
    .tx_done      (tx_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One tick_16x pulse every 4 clk, changed on the falling edge.
  always @(negedge clk) begin
    tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
    tick_16x <= tick_en && (tick_div == 3);
  end

  always @(negedge clk) begin
    if (tx_done0 === 1'b1) done0 <= done0 + 1;
    if (tx_done1 === 1'b1) done1 <= done1 + 1;
  end

  // Reference line level at sample k of a frame (one sample per tick).
  function automatic logic exp_level(input frame_t f, input int k, input int ovs, input int nb);
    int b;
    b = k / ovs;
    if (b == 0) return 1'b0;
    if (b <= nb) return f.data[b-1];
    if (f.par && b == nb + 1) return ($countones(f.data) % 2 == 0);
    return 1'b1;
  endfunction

  // Frame monitor: samples the line once per tick, pops the expected frame
  // on each start bit and compares every tick of the frame.
  task automatic monitor(input int which);
    int     ovs, nstop, k, nexp, bad_k;
    logic   pin, done, act, bad_val, bad_exp, e;
    frame_t f;
    ovs   = (which == 0) ? 16 : 8;
    nstop = (which == 0) ? 1 : 2;
    act = 1'b0; k = 0; nexp = 0; bad_k = -1; bad_val = 1'b0; bad_exp = 1'b0; f = '0;
    forever begin
      @(posedge clk);
      if (!reset) begin
        act = 1'b0;
        continue;
      end
      if (!tick_16x) continue;
      #1;
      pin  = (which == 0) ? tx_pin0 : tx_pin1;
      done = (which == 0) ? tx_done0 : tx_done1;
      if (act && k < nexp) begin
        e = exp_level(f, k, ovs, 8);
        if (bad_k < 0 && pin !== e) begin
          bad_k = k; bad_val = pin; bad_exp = e;
        end
        k++;
        continue;
      end
      if (act) begin
        checks++;
        if (bad_k >= 0) begin
          errors++;
          $display("FAIL frame%0d_bits data=%02h tick %0d: got %b expected %b",
                   which, f.data, bad_k, bad_val, bad_exp);
        end
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL frame%0d_done data=%02h: tx_done=%b expected 1", which, f.data, done);
        end
        if (pin === 1'b0) begin
          if (which == 0) b2b0++; else b2b1++;
        end
        act = 1'b0;
      end
      if (pin === 1'b0) begin
        checks++;
        if ((which == 0 && sb0.size() == 0) || (which == 1 && sb1.size() == 0)) begin
          errors++;
          $display("FAIL frame%0d_unexpected: start bit seen, expected idle line", which);
        end else begin
          if (which == 0) begin
            f = sb0.pop_front(); frames0++;
          end else begin
            f = sb1.pop_front(); frames1++;
          end
          act   = 1'b1;
          k     = 1;
          nexp  = (9 + int'(f.par) + nstop) * ovs;
          bad_k = -1;
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic send(input int which, input logic [7:0] d, input logic par);
    int n;
    logic rdy;
    n = 0;
    @(negedge clk);
    rdy = (which == 0) ? tx_ready0 : tx_ready1;
    while (!rdy && n < 3000) begin
      @(negedge clk);
      rdy = (which == 0) ? tx_ready0 : tx_ready1;
      n++;
    end
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL send%0d_ready_timeout data=%02h: tx_ready=0 expected 1", which, d);
    end
    if (which == 0) begin
      tx_data0 = d; par_en0 = par; tx_valid0 = 1'b1; sb0.push_back('{data: d, par: par});
    end else begin
      tx_data1 = d; par_en1 = par; tx_valid1 = 1'b1; sb1.push_back('{data: d, par: par});
    end
    @(negedge clk);
    rdy = (which == 0) ? tx_ready0 : tx_ready1;
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL send%0d_ready_fall data=%02h: tx_ready=%b expected 0", which, d, rdy);
    end
    if (which == 0) tx_valid0 = 1'b0; else tx_valid1 = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    int n;
    logic idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < 5000) begin
      @(negedge clk);
      idle = (which == 0) ? (!tx_busy0 && tx_ready0) : (!tx_busy1 && tx_ready1);
      n++;
    end
    if (!idle) begin
      checks++; errors++;
      $display("FAIL idle%0d_timeout: transmitter still busy, expected idle", which);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_busy0();
    int n;
    n = 0;
    while (tx_busy0 !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_busy0 !== 1'b1) begin
      errors++;
      $display("FAIL busy_timeout: tx_busy=%b expected 1", tx_busy0);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (tick_16x) c++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 8;
    if (tx_pin0 !== 1'b1)   begin errors++; $display("FAIL reset_pin0: got %b expected 1", tx_pin0); end
    if (tx_ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b expected 1", tx_ready0); end
    if (tx_busy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy0: got %b expected 0", tx_busy0); end
    if (tx_done0 !== 1'b0)  begin errors++; $display("FAIL reset_done0: got %b expected 0", tx_done0); end
    if (tx_pin1 !== 1'b1)   begin errors++; $display("FAIL reset_pin1: got %b expected 1", tx_pin1); end
    if (tx_ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready1: got %b expected 1", tx_ready1); end
    if (tx_busy1 !== 1'b0)  begin errors++; $display("FAIL reset_busy1: got %b expected 0", tx_busy1); end
    if (tx_done1 !== 1'b0)  begin errors++; $display("FAIL reset_done1: got %b expected 0", tx_done1); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int d0, n;
    d0 = done0;
    send(0, 8'h55, 1'b0);
    n = 0;
    while (tx_done0 !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_done0 !== 1'b1 || tx_busy0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done: done=%b busy=%b expected done=1 busy=0", tx_done0, tx_busy0);
    end
    wait_idle(0);
    checks++;
    if (done0 - d0 != 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d expected 1", done0 - d0);
    end
  endtask

  task automatic test_parity();
    send(0, 8'hA3, 1'b1);
    wait_idle(0);
    send(0, 8'hA2, 1'b1);
    wait_idle(0);
  endtask

  task automatic test_parity_change();
    send(0, 8'h01, 1'b1);
    wait_busy0();
    par_en0 = 1'b0;
    wait_idle(0);
    send(0, 8'h01, 1'b0);
    wait_busy0();
    par_en0 = 1'b1;
    wait_idle(0);
    par_en0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int d0, b0, n;
    d0 = done0;
    b0 = b2b0;
    @(negedge clk);
    tx_data0 = 8'h00; par_en0 = 1'b0; tx_valid0 = 1'b1;
    sb0.push_back('{data: 8'h00, par: 1'b0});
    @(negedge clk);
    tx_data0 = 8'hFF;
    sb0.push_back('{data: 8'hFF, par: 1'b0});
    n = 0;
    while (tx_ready0 !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_ready0 !== 1'b1 || tx_busy0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_on_launch: ready=%b busy=%b expected 1 1", tx_ready0, tx_busy0);
    end
    @(negedge clk);
    checks++;
    if (tx_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_accept: tx_ready=%b expected 0", tx_ready0);
    end
    tx_valid0 = 1'b0;
    wait_idle(0);
    checks += 2;
    if (done0 - d0 != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 2", done0 - d0);
    end
    if (b2b0 - b0 != 1) begin
      errors++;
      $display("FAIL b2b_no_gap: gapless starts %0d expected 1", b2b0 - b0);
    end
  endtask

  task automatic test_tick_hold();
    logic pin_ref;
    int bad;
    send(0, 8'h3C, 1'b1);
    wait_busy0();
    wait_ticks(40);
    @(posedge clk);
    #2 tick_en = 1'b0;
    @(negedge clk);
    pin_ref = tx_pin0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_pin0 !== pin_ref || tx_busy0 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tick_hold_frozen: %0d cycles changed, expected 0", bad);
    end
    @(posedge clk);
    #2 tick_en = 1'b1;
    wait_idle(0);
  endtask

  task automatic test_reset_mid_frame();
    int f0, seen_busy;
    send(0, 8'h0F, 1'b0);
    send(0, 8'hAA, 1'b0);
    wait_ticks(70);
    @(negedge clk);
    checks++;
    if (tx_ready0 !== 1'b0 || tx_busy0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_state: ready=%b busy=%b expected 0 1", tx_ready0, tx_busy0);
    end
    #1 reset = 1'b0;
    #1;
    checks += 4;
    if (tx_pin0 !== 1'b1)   begin errors++; $display("FAIL rst_async_pin: got %b expected 1", tx_pin0); end
    if (tx_ready0 !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b expected 1", tx_ready0); end
    if (tx_busy0 !== 1'b0)  begin errors++; $display("FAIL rst_async_busy: got %b expected 0", tx_busy0); end
    if (tx_done0 !== 1'b0)  begin errors++; $display("FAIL rst_async_done: got %b expected 0", tx_done0); end
    sb0.delete();
    f0 = frames0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    seen_busy = 0;
    repeat (800) begin
      @(negedge clk);
      if (tx_busy0 !== 1'b0 || tx_pin0 !== 1'b1) seen_busy++;
    end
    checks++;
    if (seen_busy != 0 || frames0 != f0) begin
      errors++;
      $display("FAIL rst_no_resume: active cycles %0d frames %0d expected 0 0",
               seen_busy, frames0 - f0);
    end
  endtask

  task automatic test_first_handshake();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tx_data0 = 8'h81; par_en0 = 1'b0; tx_valid0 = 1'b1;
    sb0.push_back('{data: 8'h81, par: 1'b0});
    @(negedge clk);
    checks++;
    if (tx_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL first_handshake: tx_ready=%b expected 0", tx_ready0);
    end
    tx_valid0 = 1'b0;
    wait_idle(0);
  endtask

  task automatic test_two_stop();
    int d1, b1;
    d1 = done1;
    b1 = b2b1;
    send(1, 8'h96, 1'b0);
    send(1, 8'h5A, 1'b1);
    wait_idle(1);
    checks += 2;
    if (done1 - d1 != 2) begin
      errors++;
      $display("FAIL two_stop_done_count: got %0d expected 2", done1 - d1);
    end
    if (b2b1 - b1 != 1) begin
      errors++;
      $display("FAIL two_stop_no_gap: gapless starts %0d expected 1", b2b1 - b1);
    end
  endtask

  initial begin
    reset = 1'b0;
    tick_en = 1'b1;
    tick_div = 0;
    tick_16x = 1'b0;
    tx_data0 = '0; tx_valid0 = 1'b0; par_en0 = 1'b0;
    tx_data1 = '0; tx_valid1 = 1'b0; par_en1 = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_parity_change();
    test_back_to_back();
    test_tick_hold();
    test_reset_mid_frame();
    test_first_handshake();
    test_two_stop();
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left %0d/%0d expected 0/0", sb0.size(), sb1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
